alu_seq_ctrl: RTL and testbench



---
 rtl/alu_seq_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_alu_seq_ctrl.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq_ctrl.sv
// alu_seq_ctrl: runs WIDTH-bit ALU operations serially through one external
// 4-bit alu4 slice, LSB slice first. The carry is held in a register between
// slices. Requests and responses use valid/ready handshakes.
module alu_seq_ctrl #(
    parameter int WIDTH  = 16,
    parameter int NSLICE = WIDTH / 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       in_op,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_result,
    output logic             out_cout,
    output logic             out_zero,
    output logic             out_overflow,
    output logic [3:0]       alu_src1,
    output logic [3:0]       alu_src2,
    output logic             alu_less,
    output logic             alu_A_invert,
    output logic             alu_B_invert,
    output logic             alu_cin,
    output logic [1:0]       alu_operation,
    input  logic [3:0]       alu_result,
    input  logic             alu_cout
);

    localparam int IW = (NSLICE > 1) ? $clog2(NSLICE) : 1;

    localparam logic [2:0] OP_AND  = 3'b000;
    localparam logic [2:0] OP_OR   = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_NOR  = 3'b100;
    localparam logic [2:0] OP_NAND = 3'b101;
    localparam logic [2:0] OP_SLT  = 3'b111;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    // Latched request: the operands stay put for the whole serial run.
    typedef struct packed {
        logic [2:0]       op;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
    } req_t;

    // Per-op alu4 control. arith marks ops that chain carry across slices.
    typedef struct packed {
        logic [1:0] operation;
        logic       a_inv;
        logic       b_inv;
        logic       cin0;
        logic       arith;
    } dec_t;

    state_t                 state, state_d;
    req_t                   req_q;
    dec_t                   dec;
    logic [IW-1:0]          idx;
    logic                   carry;
    logic [NSLICE-1:0][3:0] a_sl, b_sl, res_q, res_nx;
    logic [WIDTH-1:0]       r_full, fin_res;
    logic                   last, accept;
    logic                   a_msb, b_msb, r_msb, add_ov, sub_ov;
    logic                   fin_cout, fin_ov;

    assign a_sl     = req_q.a;
    assign b_sl     = req_q.b;
    assign last     = (idx == IW'(NSLICE - 1));
    assign accept   = in_valid && in_ready;
    assign alu_less = 1'b0;

    // Decode the latched opcode into alu4 controls; reserved uses AND encoding.
    always_comb begin
        dec = '0;
        case (req_q.op)
            OP_AND:  dec = '{operation: 2'b00, a_inv: 1'b0, b_inv: 1'b0, cin0: 1'b0, arith: 1'b0};
            OP_OR:   dec = '{operation: 2'b01, a_inv: 1'b0, b_inv: 1'b0, cin0: 1'b0, arith: 1'b0};
            OP_ADD:  dec = '{operation: 2'b10, a_inv: 1'b0, b_inv: 1'b0, cin0: 1'b0, arith: 1'b1};
            OP_SUB,
            OP_SLT:  dec = '{operation: 2'b10, a_inv: 1'b0, b_inv: 1'b1, cin0: 1'b1, arith: 1'b1};
            OP_NOR:  dec = '{operation: 2'b00, a_inv: 1'b1, b_inv: 1'b1, cin0: 1'b0, arith: 1'b0};
            OP_NAND: dec = '{operation: 2'b01, a_inv: 1'b1, b_inv: 1'b1, cin0: 1'b0, arith: 1'b0};
            default: dec = '0;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_d;
    end

    // Next state plus the handshake and alu4 drive. The alu4 is idle outside RUN.
    always_comb begin
        state_d       = state;
        in_ready      = 1'b0;
        alu_src1      = 4'h0;
        alu_src2      = 4'h0;
        alu_A_invert  = 1'b0;
        alu_B_invert  = 1'b0;
        alu_cin       = 1'b0;
        alu_operation = 2'b00;
        case (state)
            IDLE: begin
                in_ready = !rst;
                if (in_valid && !rst) state_d = RUN;
            end
            RUN: begin
                alu_src1      = a_sl[idx];
                alu_src2      = b_sl[idx];
                alu_A_invert  = dec.a_inv;
                alu_B_invert  = dec.b_inv;
                alu_operation = dec.operation;
                alu_cin       = (idx == '0) ? dec.cin0 : (dec.arith & carry);
                if (last) state_d = DONE;
            end
            DONE: begin
                if (out_valid && out_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Merge the slice arriving this cycle so the final flags see every bit.
    always_comb begin
        res_nx      = res_q;
        res_nx[idx] = alu_result;
    end

    assign r_full = res_nx;
    assign a_msb  = req_q.a[WIDTH-1];
    assign b_msb  = req_q.b[WIDTH-1];
    assign r_msb  = r_full[WIDTH-1];
    assign add_ov = (a_msb == b_msb) && (r_msb != a_msb);
    assign sub_ov = (a_msb != b_msb) && (r_msb != a_msb);

    // Final result and flags, evaluated on the edge that captures the MSB slice.
    always_comb begin
        fin_res  = r_full;
        fin_cout = 1'b0;
        fin_ov   = 1'b0;
        case (req_q.op)
            OP_ADD: begin
                fin_cout = alu_cout;
                fin_ov   = add_ov;
            end
            OP_SUB: begin
                fin_cout = alu_cout;
                fin_ov   = sub_ov;
            end
            OP_SLT: begin
                fin_res  = {{(WIDTH-1){1'b0}}, r_msb ^ sub_ov};
                fin_cout = alu_cout;
            end
            OP_AND, OP_OR, OP_NOR, OP_NAND: fin_res = r_full;
            default: fin_res = '0;
        endcase
    end

    // Datapath: latch on accept, step one slice per cycle, publish on the last one.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            req_q        <= '0;
            idx          <= '0;
            carry        <= 1'b0;
            res_q        <= '0;
            out_valid    <= 1'b0;
            out_result   <= '0;
            out_cout     <= 1'b0;
            out_zero     <= 1'b0;
            out_overflow <= 1'b0;
        end else begin
            if (accept) begin
                req_q <= '{op: in_op, a: in_a, b: in_b};
                idx   <= '0;
                carry <= 1'b0;
            end
            if (state == RUN) begin
                res_q <= res_nx;
                carry <= alu_cout;
                idx   <= last ? '0 : idx + 1'b1;
                if (last) begin
                    out_valid    <= 1'b1;
                    out_result   <= fin_res;
                    out_cout     <= fin_cout;
                    out_zero     <= (fin_res == '0);
                    out_overflow <= fin_ov;
                end
            end
            if (out_valid && out_ready) out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb_alu_seq_ctrl: directed vectors through alu_seq_ctrl with a behavioural alu4.
module tb_alu_seq_ctrl;

    localparam int WIDTH = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [2:0]       in_op = 3'b000;
    logic [WIDTH-1:0] in_a = '0;
    logic [WIDTH-1:0] in_b = '0;
    logic             out_valid;
    logic             out_ready = 1'b1;
    logic [WIDTH-1:0] out_result;
    logic             out_cout, out_zero, out_overflow;
    logic [3:0]       alu_src1, alu_src2, alu_result;
    logic             alu_less, alu_A_invert, alu_B_invert, alu_cin, alu_cout;
    logic [1:0]       alu_operation;

    int n_checks = 0;
    int n_errors = 0;

    alu_seq_ctrl #(.WIDTH(WIDTH)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op), .in_a(in_a), .in_b(in_b),
        .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
        .out_cout(out_cout), .out_zero(out_zero), .out_overflow(out_overflow),
        .alu_src1(alu_src1), .alu_src2(alu_src2), .alu_less(alu_less),
        .alu_A_invert(alu_A_invert), .alu_B_invert(alu_B_invert), .alu_cin(alu_cin),
        .alu_operation(alu_operation), .alu_result(alu_result), .alu_cout(alu_cout)
    );

    always #5 clk = ~clk;

    // Behavioural alu4 slice: optional input inversion, then AND/OR/ADD/less.
    logic [3:0] m_a, m_b;
    logic [4:0] m_sum;
    always_comb begin
        m_a   = alu_A_invert ? ~alu_src1 : alu_src1;
        m_b   = alu_B_invert ? ~alu_src2 : alu_src2;
        m_sum = {1'b0, m_a} + {1'b0, m_b} + {4'b0, alu_cin};
        alu_cout = m_sum[4];
        case (alu_operation)
            2'b00:   alu_result = m_a & m_b;
            2'b01:   alu_result = m_a | m_b;
            2'b10:   alu_result = m_sum[3:0];
            default: alu_result = {3'b000, alu_less};
        endcase
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Expected alu4 controls per opcode: {operation[1:0], A_invert, B_invert, slice-0 cin}.
    function automatic logic [4:0] dec_exp(input logic [2:0] op);
        case (op)
            3'b000:  return 5'b00_0_0_0;
            3'b001:  return 5'b01_0_0_0;
            3'b010:  return 5'b10_0_0_0;
            3'b011:  return 5'b10_0_1_1;
            3'b100:  return 5'b00_1_1_0;
            3'b101:  return 5'b01_1_1_0;
            3'b111:  return 5'b10_0_1_1;
            default: return 5'b00_0_0_0;
        endcase
    endfunction

    // Present a request and return at the negedge after the accept edge.
    task automatic send(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b);
        int w;
        @(negedge clk);
        in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
        w = 0;
        while (!in_ready && w < 50) begin
            @(negedge clk);
            w++;
        end
        if (w >= 50) check("send_timeout", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Follow RUN slice by slice, then check latency, result and flags.
    task automatic wait_result(input string tag, input logic [2:0] op,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [15:0] e_res, input logic e_cout,
                               input logic e_zero, input logic e_ov);
        logic [4:0]  d;
        logic [15:0] sa, sb;
        int          lat;
        d   = dec_exp(op);
        lat = 0;
        while (!out_valid && lat < 20) begin
            if (lat < 4) begin
                sa = a >> (4 * lat);
                sb = b >> (4 * lat);
                check({tag, "_opc"}, 32'(alu_operation), 32'(d[4:3]));
                check({tag, "_ainv"}, 32'(alu_A_invert), 32'(d[2]));
                check({tag, "_binv"}, 32'(alu_B_invert), 32'(d[1]));
                check({tag, "_src1"}, 32'(alu_src1), 32'(sa[3:0]));
                check({tag, "_src2"}, 32'(alu_src2), 32'(sb[3:0]));
                if (lat == 0) check({tag, "_cin0"}, 32'(alu_cin), 32'(d[0]));
            end
            @(negedge clk);
            lat++;
        end
        check({tag, "_lat"}, 32'(lat), 32'd4);
        check({tag, "_res"}, 32'(out_result), 32'(e_res));
        check({tag, "_cout"}, 32'(out_cout), 32'(e_cout));
        check({tag, "_zero"}, 32'(out_zero), 32'(e_zero));
        check({tag, "_ovf"}, 32'(out_overflow), 32'(e_ov));
        check({tag, "_alu_idle"}, 32'({alu_operation, alu_src1, alu_src2, alu_cin}), 32'd0);
    endtask

    // Full op with out_ready high: response drains on the next edge.
    task automatic do_op(input string tag, input logic [2:0] op,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [15:0] e_res, input logic e_cout,
                         input logic e_zero, input logic e_ov);
        send(op, a, b);
        wait_result(tag, op, a, b, e_res, e_cout, e_zero, e_ov);
        @(negedge clk);
        check({tag, "_drain_vld"}, 32'(out_valid), 32'd0);
        check({tag, "_drain_rdy"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset state.
        repeat (2) @(negedge clk);
        check("rst_vld", 32'(out_valid), 32'd0);
        check("rst_res", 32'(out_result), 32'd0);
        check("rst_flags", 32'({out_cout, out_zero, out_overflow}), 32'd0);
        check("rst_alu", 32'({alu_src1, alu_src2, alu_less, alu_A_invert, alu_B_invert,
                             alu_cin, alu_operation}), 32'd0);
        check("rst_rdy_in_rst", 32'(in_ready), 32'd0);
        rst = 1'b0;
        #1;
        check("rst_rdy", 32'(in_ready), 32'd1);

        // Arithmetic.
        do_op("add_ovf", 3'b010, 16'h7FFF, 16'h0001, 16'h8000, 1'b0, 1'b0, 1'b1);
        do_op("sub_eq",  3'b011, 16'h0005, 16'h0005, 16'h0000, 1'b1, 1'b1, 1'b0);
        do_op("add_wrap", 3'b010, 16'hFFFF, 16'h0001, 16'h0000, 1'b1, 1'b1, 1'b0);

        // Set-less-than.
        do_op("slt_neg", 3'b111, 16'hFFFE, 16'h0003, 16'h0001, 1'b1, 1'b0, 1'b0);
        do_op("slt_ovf", 3'b111, 16'h8000, 16'h7FFF, 16'h0001, 1'b1, 1'b0, 1'b0);
        do_op("slt_ge",  3'b111, 16'h0003, 16'hFFFE, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Logic ops and the reserved opcode.
        do_op("and",  3'b000, 16'h0F0F, 16'h00FF, 16'h000F, 1'b0, 1'b0, 1'b0);
        do_op("or",   3'b001, 16'h0F0F, 16'h00FF, 16'h0FFF, 1'b0, 1'b0, 1'b0);
        do_op("nor",  3'b100, 16'h0F0F, 16'h00FF, 16'hF000, 1'b0, 1'b0, 1'b0);
        do_op("nand", 3'b101, 16'h0F0F, 16'h00FF, 16'hFFF0, 1'b0, 1'b0, 1'b0);
        do_op("rsvd", 3'b110, 16'h0F0F, 16'h00FF, 16'h0000, 1'b0, 1'b1, 1'b0);

        // Backpressure: response held while a new request waits.
        out_ready = 1'b0;
        send(3'b010, 16'h1234, 16'h1111);
        wait_result("bp", 3'b010, 16'h1234, 16'h1111, 16'h2345, 1'b0, 1'b0, 1'b0);
        in_op = 3'b011; in_a = 16'h0010; in_b = 16'h0001; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("bp_hold_vld", 32'(out_valid), 32'd1);
            check("bp_hold_res", 32'(out_result), 32'h2345);
            check("bp_hold_flags", 32'({out_cout, out_zero, out_overflow}), 32'd0);
            check("bp_hold_rdy", 32'(in_ready), 32'd0);
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_vld", 32'(out_valid), 32'd0);
        check("bp_release_rdy", 32'(in_ready), 32'd1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        wait_result("bp_next", 3'b011, 16'h0010, 16'h0001, 16'h000F, 1'b1, 1'b0, 1'b0);
        @(negedge clk);

        // Reset in the middle of an ADD whose carry register is set.
        send(3'b010, 16'h00FF, 16'h0001);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_vld", 32'(out_valid), 32'd0);
        check("mid_rst_alu", 32'({alu_src1, alu_src2, alu_less, alu_A_invert, alu_B_invert,
                                 alu_cin, alu_operation}), 32'd0);
        check("mid_rst_rdy", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("mid_rst_rdy_after", 32'(in_ready), 32'd1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("mid_rst_no_vld", 32'(out_valid), 32'd0);
        end
        do_op("post_rst", 3'b010, 16'h0001, 16'h0001, 16'h0002, 1'b0, 1'b0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
